// File: rtl/dma_cpu_bus_master_pkg.sv
// Shared types and constants for the CPU-side DMA bus master.
package dma_cpu_bus_master_pkg;

    // Bus cycle states: T1 address/ALE, T2-T3 strobe, T4 recovery, HOLD yielded.
    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_HOLD
    } bus_state_t;

    // Which of the four active-low strobes a cycle uses.
    typedef enum logic [1:0] {
        STB_IOR,
        STB_IOW,
        STB_MEMR,
        STB_MEMW
    } strobe_sel_t;

    // DMA controller register codes (low nibble of the I/O address).
    localparam logic [3:0] CH0_ADDR         = 4'h0;
    localparam logic [3:0] CH0_WC           = 4'h1;
    localparam logic [3:0] CH1_ADDR         = 4'h2;
    localparam logic [3:0] CH1_WC           = 4'h3;
    localparam logic [3:0] CH2_ADDR         = 4'h4;
    localparam logic [3:0] CH2_WC           = 4'h5;
    localparam logic [3:0] CH3_ADDR         = 4'h6;
    localparam logic [3:0] CH3_WC           = 4'h7;
    localparam logic [3:0] COMMAND_REGISTER = 4'h8;
    localparam logic [3:0] MODE_REGISTER    = 4'hB;
    localparam logic [3:0] CLEAR_BPFF       = 4'hC;
    localparam logic [3:0] MASTER_CLEAR     = 4'hD;

    // Map cycle direction and space onto the strobe to assert.
    function automatic strobe_sel_t strobe_select(input logic rd_nwr, input logic io_nmem);
        case ({io_nmem, rd_nwr})
            2'b01:   strobe_select = STB_IOR;
            2'b00:   strobe_select = STB_IOW;
            2'b11:   strobe_select = STB_MEMR;
            default: strobe_select = STB_MEMW;
        endcase
    endfunction

endpackage

// File: rtl/dma_cpu_bus_master_mux_address_latch.sv
// ALE-gated demultiplexer: transparent while ALE is high, holds afterwards.
module mux_address_latch #(
    parameter int AW = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          ale,
    input  logic [AW-1:0] ad_in,
    output logic [AW-1:0] lat_addr
);

    logic [AW-1:0] addr_q;

    // Capture the AD bus on every edge that sees ALE high.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            addr_q <= '0;
        else if (ale)
            addr_q <= ad_in;
    end

    assign lat_addr = ale ? ad_in : addr_q;

endmodule

// File: rtl/dma_cpu_bus_master.sv
// CPU-side master for the multiplexed AD bus, with HRQ/HLDA bus yield.
module dma_cpu_bus_master
    import dma_cpu_bus_master_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          req,
    input  logic          rd_nwr,
    input  logic          io_nmem,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          busy,
    input  logic          ready,
    input  logic [AW-1:0] ad_in,
    output logic [AW-1:0] ad_out,
    output logic          ad_oe,
    output logic          ALE,
    output logic [AW-1:0] lat_addr,
    output logic          nIOR,
    output logic          nIOW,
    output logic          nMEMR,
    output logic          nMEMW,
    output logic          ctl_oe,
    input  logic          hrq,
    output logic          hlda
);

    bus_state_t    state, next_state;
    logic          cur_rd;
    logic          cur_io;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic          strobe_on;

    // Accept a request only from IDLE and only when no hold is pending.
    logic accept;
    assign accept = (state == S_IDLE) && !hrq && req;

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Snapshot the request so the bus stays stable even if req inputs change.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cur_rd    <= 1'b0;
            cur_io    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
        end else if (accept) begin
            cur_rd    <= rd_nwr;
            cur_io    <= io_nmem;
            cur_addr  <= addr;
            cur_wdata <= wdata;
        end
    end

    // Read data is taken on the edge that leaves T3 with the slave ready.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            rdata <= '0;
        else if (state == S_T3 && ready && cur_rd)
            rdata <= DW'(ad_in);
    end

    // HLDA rises one cycle into HOLD and drops on the edge that leaves it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            hlda <= 1'b0;
        else
            hlda <= (state == S_HOLD) && hrq;
    end

    // Next-state and bus outputs decoded from state only (no req-to-bus path).
    always_comb begin
        next_state = state;
        ad_out     = '0;
        ad_oe      = 1'b0;
        ALE        = 1'b0;
        ctl_oe     = 1'b1;
        done       = 1'b0;
        busy       = 1'b0;
        strobe_on  = 1'b0;
        case (state)
            S_IDLE: begin
                if (hrq)
                    next_state = S_HOLD;
                else if (req)
                    next_state = S_T1;
            end
            S_T1: begin
                busy       = 1'b1;
                ad_out     = cur_addr;
                ad_oe      = 1'b1;
                ALE        = 1'b1;
                next_state = S_T2;
            end
            S_T2, S_T3: begin
                busy      = 1'b1;
                strobe_on = 1'b1;
                if (!cur_rd) begin
                    ad_out = AW'(cur_wdata);
                    ad_oe  = 1'b1;
                end
                if (state == S_T2)
                    next_state = S_T3;
                else if (ready)
                    next_state = S_T4;
            end
            S_T4: begin
                // Strobe is released but write data is held one more cycle.
                busy = 1'b1;
                done = 1'b1;
                if (!cur_rd) begin
                    ad_out = AW'(cur_wdata);
                    ad_oe  = 1'b1;
                end
                next_state = S_IDLE;
            end
            S_HOLD: begin
                ctl_oe = 1'b0;
                if (!hrq)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Strobe decode from the latched cycle type.
    always_comb begin
        nIOR  = 1'b1;
        nIOW  = 1'b1;
        nMEMR = 1'b1;
        nMEMW = 1'b1;
        if (strobe_on) begin
            case (strobe_select(cur_rd, cur_io))
                STB_IOR:  nIOR  = 1'b0;
                STB_IOW:  nIOW  = 1'b0;
                STB_MEMR: nMEMR = 1'b0;
                default:  nMEMW = 1'b0;
            endcase
        end
    end

    mux_address_latch #(.AW(AW)) u_addr_latch (
        .Clock    (Clock),
        .Reset    (Reset),
        .ale      (ALE),
        .ad_in    (ad_in),
        .lat_addr (lat_addr)
    );

endmodule

// File: tb/tb_dma_cpu_bus_master.sv
// Directed table-driven bench for the CPU bus master.
module tb_dma_cpu_bus_master;
    import dma_cpu_bus_master_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        req = 0, rd_nwr = 0, io_nmem = 0, ready = 1, hrq = 0;
    logic [15:0] addr = '0, wdata = '0, slv = '0;
    logic [15:0] rdata, ad_in, ad_out, lat_addr;
    logic        done, busy, ad_oe, ALE, nIOR, nIOW, nMEMR, nMEMW, ctl_oe, hlda;

    int tests = 0;
    int failed = 0;

    // Shared bus: the master drives when enabled, otherwise the slave/DMA.
    assign ad_in = ad_oe ? ad_out : slv;

    always #5 Clock = ~Clock;

    dma_cpu_bus_master #(.AW(16), .DW(16)) dut (
        .Clock(Clock), .Reset(Reset), .req(req), .rd_nwr(rd_nwr), .io_nmem(io_nmem),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .ready(ready), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .ALE(ALE),
        .lat_addr(lat_addr), .nIOR(nIOR), .nIOW(nIOW), .nMEMR(nMEMR), .nMEMW(nMEMW),
        .ctl_oe(ctl_oe), .hrq(hrq), .hlda(hlda)
    );

    typedef struct packed {
        logic        req, rd, io, rdy, hrq;
        logic [15:0] addr, wdata, slv;
    } in_t;

    typedef struct packed {
        logic [15:0] ad_out;
        logic        ad_oe, ale;
        logic [15:0] lat;
        logic [3:0]  stb;   // {nIOR, nIOW, nMEMR, nMEMW}
        logic        ctl_oe, done, busy, hlda;
        logic [15:0] rdata;
    } obs_t;

    typedef struct {
        in_t  i;
        obs_t e;
        bit   busy_dc;
    } vec_t;

    vec_t tbl[$];
    obs_t act;
    assign act = {ad_out, ad_oe, ALE, lat_addr, nIOR, nIOW, nMEMR, nMEMW,
                  ctl_oe, done, busy, hlda, rdata};

    function automatic in_t ip(logic r, logic rd, logic io, logic rdy, logic h,
                               logic [15:0] a, logic [15:0] w, logic [15:0] s);
        ip = {r, rd, io, rdy, h, a, w, s};
    endfunction

    function automatic obs_t ob(logic [15:0] ao, logic oe, logic ale, logic [15:0] la,
                                logic [3:0] stb, logic ctl, logic dn, logic bz,
                                logic hl, logic [15:0] rd);
        ob = {ao, oe, ale, la, stb, ctl, dn, bz, hl, rd};
    endfunction

    task automatic add(input in_t i, input obs_t e, input bit dc = 0);
        vec_t v;
        v.i = i; v.e = e; v.busy_dc = dc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic drive(input in_t i);
        req = i.req; rd_nwr = i.rd; io_nmem = i.io; ready = i.rdy; hrq = i.hrq;
        addr = i.addr; wdata = i.wdata; slv = i.slv;
    endtask

    localparam logic [15:0] A0 = {12'hFFF, CH0_ADDR};
    localparam logic [15:0] A1 = {12'hFFF, COMMAND_REGISTER};
    localparam logic [15:0] A2 = 16'h1234;
    localparam logic [15:0] A3 = 16'h2000;
    localparam logic [15:0] A4 = {12'hFFF, MASTER_CLEAR};
    localparam logic [15:0] W0 = 16'hA500;
    localparam logic [15:0] W2 = 16'h5A00;
    localparam logic [15:0] W4 = 16'h0300;

    obs_t care;
    obs_t rst_obs;
    int   k;
    bit   saw_done;

    initial begin
        rst_obs = ob(16'h0, 0, 0, 16'h0, 4'hF, 1, 0, 0, 0, 16'h0);

        // I/O write, no wait states.
        add(ip(1,0,0,1,0,A0,W0,0), ob(0,  0,0,16'h0,4'hF,1,0,0,0,0));
        add(ip(1,0,0,1,0,A0,W0,0), ob(A0, 1,1,A0,   4'hF,1,0,1,0,0));
        add(ip(1,0,0,1,0,A0,W0,0), ob(W0, 1,0,A0,   4'hB,1,0,1,0,0));
        add(ip(1,0,0,1,0,A0,W0,0), ob(W0, 1,0,A0,   4'hB,1,0,1,0,0));
        add(ip(0,0,0,1,0,A0,W0,0), ob(W0, 1,0,A0,   4'hF,1,1,1,0,0), 1);
        add(ip(0,0,0,1,0,A0,W0,0), ob(0,  0,0,A0,   4'hF,1,0,0,0,0));
        // I/O read, slave returns 1000.
        add(ip(1,1,0,1,0,A1,0,16'h1000), ob(0, 0,0,A0,4'hF,1,0,0,0,0));
        add(ip(1,1,0,1,0,A1,0,16'h1000), ob(A1,1,1,A1,4'hF,1,0,1,0,0));
        add(ip(1,1,0,1,0,A1,0,16'h1000), ob(0, 0,0,A1,4'h7,1,0,1,0,0));
        add(ip(1,1,0,1,0,A1,0,16'h1000), ob(0, 0,0,A1,4'h7,1,0,1,0,0));
        add(ip(0,1,0,1,0,A1,0,16'h1000), ob(0, 0,0,A1,4'hF,1,1,1,0,16'h1000), 1);
        add(ip(0,1,0,1,0,A1,0,16'h1000), ob(0, 0,0,A1,4'hF,1,0,0,0,16'h1000));
        // Memory write with two wait states in T3.
        add(ip(1,0,1,0,0,A2,W2,0), ob(0, 0,0,A1,4'hF,1,0,0,0,16'h1000));
        add(ip(1,0,1,0,0,A2,W2,0), ob(A2,1,1,A2,4'hF,1,0,1,0,16'h1000));
        add(ip(1,0,1,0,0,A2,W2,0), ob(W2,1,0,A2,4'hE,1,0,1,0,16'h1000));
        add(ip(1,0,1,0,0,A2,W2,0), ob(W2,1,0,A2,4'hE,1,0,1,0,16'h1000));
        add(ip(1,0,1,0,0,A2,W2,0), ob(W2,1,0,A2,4'hE,1,0,1,0,16'h1000));
        add(ip(1,0,1,1,0,A2,W2,0), ob(W2,1,0,A2,4'hE,1,0,1,0,16'h1000));
        add(ip(0,0,1,1,0,A2,W2,0), ob(W2,1,0,A2,4'hF,1,1,1,0,16'h1000), 1);
        add(ip(0,0,1,1,0,A2,W2,0), ob(0, 0,0,A2,4'hF,1,0,0,0,16'h1000));
        // hrq and req together in IDLE: HOLD first, then the memory read.
        add(ip(1,1,1,1,1,A3,0,16'h3C00), ob(0, 0,0,A2,4'hF,1,0,0,0,16'h1000));
        add(ip(1,1,1,1,1,A3,0,16'h3C00), ob(0, 0,0,A2,4'hF,0,0,0,0,16'h1000));
        add(ip(1,1,1,1,1,A3,0,16'hDEAD), ob(0, 0,0,A2,4'hF,0,0,0,1,16'h1000));
        add(ip(1,1,1,1,0,A3,0,16'h3C00), ob(0, 0,0,A2,4'hF,0,0,0,1,16'h1000));
        add(ip(1,1,1,1,0,A3,0,16'h3C00), ob(0, 0,0,A2,4'hF,1,0,0,0,16'h1000));
        add(ip(1,1,1,1,0,A3,0,16'h3C00), ob(A3,1,1,A3,4'hF,1,0,1,0,16'h1000));
        add(ip(1,1,1,1,0,A3,0,16'h3C00), ob(0, 0,0,A3,4'hD,1,0,1,0,16'h1000));
        add(ip(1,1,1,1,0,A3,0,16'h3C00), ob(0, 0,0,A3,4'hD,1,0,1,0,16'h1000));
        add(ip(0,1,1,1,0,A3,0,16'h3C00), ob(0, 0,0,A3,4'hF,1,1,1,0,16'h3C00), 1);
        add(ip(0,1,1,1,0,A3,0,16'h3C00), ob(0, 0,0,A3,4'hF,1,0,0,0,16'h3C00));
        // hrq raised mid-cycle: cycle completes, then HOLD.
        add(ip(1,0,0,1,0,A4,W4,0), ob(0, 0,0,A3,4'hF,1,0,0,0,16'h3C00));
        add(ip(1,0,0,1,0,A4,W4,0), ob(A4,1,1,A4,4'hF,1,0,1,0,16'h3C00));
        add(ip(1,0,0,1,1,A4,W4,0), ob(W4,1,0,A4,4'hB,1,0,1,0,16'h3C00));
        add(ip(1,0,0,1,1,A4,W4,0), ob(W4,1,0,A4,4'hB,1,0,1,0,16'h3C00));
        add(ip(0,0,0,1,1,A4,W4,0), ob(W4,1,0,A4,4'hF,1,1,1,0,16'h3C00), 1);
        add(ip(0,0,0,1,1,A4,W4,0), ob(0, 0,0,A4,4'hF,1,0,0,0,16'h3C00));
        add(ip(0,0,0,1,1,A4,W4,0), ob(0, 0,0,A4,4'hF,0,0,0,0,16'h3C00));
        add(ip(0,0,0,1,0,A4,W4,0), ob(0, 0,0,A4,4'hF,0,0,0,1,16'h3C00));
        add(ip(0,0,0,1,0,A4,W4,0), ob(0, 0,0,A4,4'hF,1,0,0,0,16'h3C00));

        // Reset state.
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("reset_state", 64'(act), 64'(rst_obs));
        Reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge Clock);
            drive(tbl[i].i);
            #1;
            care = '1;
            if (!tbl[i].e.ad_oe) care.ad_out = '0;
            if (tbl[i].busy_dc)  care.busy   = 1'b0;
            chk($sformatf("row%0d", i), 64'(act & care), 64'(tbl[i].e & care));
        end

        // Reset asserted in T2 of an I/O read aborts the cycle with no done.
        @(negedge Clock);
        drive(ip(1,1,0,1,0,16'hFFF4,0,16'h7700));
        @(negedge Clock);
        @(negedge Clock);
        #1 chk("t2_nIOR", 64'(nIOR), 64'(0));
        Reset = 1'b1;
        req   = 1'b0;
        #1 chk("async_reset", 64'(act), 64'(rst_obs));
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            if (done || busy) saw_done = 1;
        end
        chk("no_done_after_reset", 64'(saw_done), 64'(0));

        // req held through done starts a fresh cycle.
        @(negedge Clock);
        drive(ip(1,0,0,1,0,{12'hFFF, MODE_REGISTER},16'h4800,0));
        k = 11;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clock);
            #1;
            if (done) begin
                k = c;
                break;
            end
        end
        chk("done_latency", 64'(k), 64'(4));
        @(negedge Clock);
        @(negedge Clock);
        #1 chk("back_to_back_T1", 64'({ALE, busy, ad_out}), 64'({1'b1, 1'b1, 12'hFFF, MODE_REGISTER}));
        req = 1'b0;
        repeat (5) @(negedge Clock);
        #1 chk("idle_after_b2b", 64'({busy, ad_oe}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dma_cpu_bus_master.md
Name: dma_cpu_bus_master

Overview:
Synthesizable CPU-side bus master for the DMA subsystem. It runs single read/write cycles on a multiplexed 16-bit AD bus with ALE, and demultiplexes the address onto a stable address bus. It yields the bus to the DMA controller through an HRQ/HLDA hold handshake. It sits between the host command port and the system bus shared with memory, I/O devices and the DMA controller.

Parameters:
AW, 16, address/AD bus width
DW, 16, data width (register data travels in byte [15:8], low byte 0)

Ports:
Clock  in  1  system clock, all flops rising-edge
Reset  in  1  asynchronous, active-high
req  in  1  cycle request (level); held until done
rd_nwr  in  1  1=read, 0=write
io_nmem  in  1  0=I/O cycle, 1=memory cycle
addr  in  AW  cycle address (e.g. {12'hFFF, 4-bit register code})
wdata  in  DW  write data
rdata  out  DW  captured read data
done  out  1  one-cycle completion pulse
busy  out  1  cycle in progress
ready  in  1  slave ready; low in T3 inserts wait states
ad_in  in  AW  AD bus sampled value
ad_out  out  AW  AD bus drive value
ad_oe  out  1  AD bus output enable
ALE  out  1  address latch enable
lat_addr  out  AW  demultiplexed address
nIOR, nIOW, nMEMR, nMEMW  out  1 each  active-low strobes
ctl_oe  out  1  strobe output enable (0 = floated)
hrq  in  1  DMA hold request
hlda  out  1  hold acknowledge

Behaviour:
- Reset values: state IDLE; ad_oe=0, ad_out=0, ALE=0; all strobes=1; ctl_oe=1; lat_addr=0; rdata=0; done=0; busy=0; hlda=0.
- States: IDLE, T1, T2, T3, T4, HOLD.
- IDLE:
  - If hrq=1, go to HOLD. hrq has priority over a simultaneous req; the req stays pending.
  - Otherwise, if req=1, latch rd_nwr, io_nmem, addr and wdata, then go to T1 with busy=1.
- T1: ad_out=addr, ad_oe=1, ALE=1.
- T2:
  - ALE=0.
  - Strobe asserted per the latched rd_nwr and io_nmem.
  - Write: ad_out=wdata, ad_oe=1. Read: ad_oe=0.
- T3: strobe held. If ready=0, stay in T3. If ready=1 on a read, rdata<=ad_in on the leaving edge. Go to T4.
- T4:
  - Strobe deasserted; write data still driven for hold time.
  - done=1 for this cycle only.
  - Next state IDLE; busy=0, ad_oe=0.
- Latency: an accepted request completes done 4 cycles after acceptance with no wait states; each ready=0 cycle adds one cycle.
- req is ignored while busy. The requester must drop req or present a new cycle after done; req still high after done starts a new cycle.
- HOLD:
  - hlda=1 registered one cycle after entry; ad_oe=0, ctl_oe=0, ALE=0.
  - When hrq=0, hlda=0 and return to IDLE. A hold is never granted mid-cycle.
- Address latch:
  - Register loads ad_in on every edge with ALE=1.
  - lat_addr = ALE ? ad_in : register (flow-through while ALE high, held after the falling edge).
  - Holds its value during HOLD so DMA-driven addresses are not disturbed.
- Reset mid-cycle: immediate return to IDLE with all reset values; the aborted cycle produces no done.
- No combinational path from req to bus outputs.

Decomposition:
- Shared package: bus-state enum; strobe-select encoding; DMA register address codes (CLEAR_BPFF, MASTER_CLEAR, COMMAND_REGISTER, MODE_REGISTER, channel address/word-count codes), reused from the existing DMA register code package.
- Sub-module mux_address_latch (ALE-gated AD demultiplexer); the FSM lives in the top.

Test Plan:
- I/O write: addr=16'hFFF0, wdata=16'hA500, io_nmem=0 -> T1: ad_out=FFF0, ALE=1; T2–T3: nIOW=0, ad_out=A500; lat_addr=FFF0 throughout; done on 4th cycle.
- I/O read with the slave driving ad_in=16'h1000 in T3 -> nIOR low T2–T3, rdata=16'h1000 after done, ad_oe=0 during T2–T4.
- ready=0 for 2 cycles in T3 on a memory write (io_nmem=1) -> nMEMW low 4 cycles, done at cycle 6.
- hrq asserted mid-cycle -> cycle completes, then hlda=1 one cycle after IDLE; ad_oe=ctl_oe=0; hrq low -> hlda=0 next cycle; the pending req then runs.
- hrq and req high together in IDLE -> HOLD taken first; request executes after hrq drops.
- Reset asserted in T2 -> all strobes 1, ALE 0, busy 0 immediately (async); no done pulse.
